// File: rtl/gap_feedback_monitor_pkg.sv
// Shared definitions for the gap feedback monitor.
// spi_slave_cmd and host-side decoding use the same definitions:
//   - classifier FSM state encodings (exposed on the debug state port)
//   - pulse class codes carried by the classifier commit
//   - bit offsets of the fields inside the 32-bit feedback word
//   - an 8-bit saturating increment shared by the statistics counters
package gap_feedback_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_WAIT_BD = 2'd2,
    ST_HOLD    = 2'd3
  } gap_state_e;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_SHORT  = 2'd2,
    CLS_OPEN   = 2'd3
  } gap_class_e;

  localparam int FB_FIELD_W    = 8;
  localparam int FB_NORMAL_LSB = 24;
  localparam int FB_SHORT_LSB  = 16;
  localparam int FB_OPEN_LSB   = 8;
  localparam int FB_DELAY_LSB  = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gap_feedback_monitor_if.sv
// Signal bundle between the discharge/ADC side and the gap feedback monitor.
//   enable, pulse_on, sample_voltage, sample_current : into the monitor
//   feedback_data, feedback_valid                    : out of the monitor
//   dbg_state, dbg_current                           : debug observation
// Handshake: feedback_valid is a one-cycle strobe with no ready/back-pressure.
// The consumer captures feedback_data in the strobe cycle; feedback_data then
// holds until the next strobe or reset.
interface gap_feedback_monitor_if;
  import gap_feedback_monitor_pkg::*;

  logic        enable;
  logic        pulse_on;
  logic [15:0] sample_voltage;
  logic [15:0] sample_current;
  logic [31:0] feedback_data;
  logic        feedback_valid;
  gap_state_e  dbg_state;
  logic [15:0] dbg_current;

  modport master (
    output enable, pulse_on, sample_voltage, sample_current,
    input  feedback_data, feedback_valid, dbg_state, dbg_current
  );

  modport slave (
    input  enable, pulse_on, sample_voltage, sample_current,
    output feedback_data, feedback_valid, dbg_state, dbg_current
  );

endinterface

// File: rtl/gap_feedback_monitor_classifier.sv
// gap_pulse_classifier: pulse_on rising-edge detect, per-pulse classifier FSM
// and ignition-delay counter.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   enable           classifier runs only while high (FSM forced to IDLE else)
//   pulse_on         discharge pulse applied
//   sample_voltage   gap voltage code
//   commit_valid     one-cycle pulse: a classification is final this cycle
//   commit_class     NORMAL / SHORT / OPEN when commit_valid
//   commit_delay     ignition delay in cycles (saturating) for NORMAL commits
//   state_o          current FSM state for debug
module gap_pulse_classifier
  import gap_feedback_monitor_pkg::*;
#(
  parameter int          BLANK_CYCLES = 8,
  parameter logic [15:0] V_OPEN_TH    = 16'd2000,
  parameter logic [15:0] V_SHORT_TH   = 16'd300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pulse_on,
  input  logic [15:0] sample_voltage,
  output logic        commit_valid,
  output gap_class_e  commit_class,
  output logic [15:0] commit_delay,
  output gap_state_e  state_o
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  gap_state_e  state_q, state_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [15:0] delay_q, delay_d;
  logic        pulse_prev_q, pulse_prev_d;
  logic        rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      blank_q      <= '0;
      delay_q      <= '0;
      pulse_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_q      <= blank_d;
      delay_q      <= delay_d;
      pulse_prev_q <= pulse_prev_d;
    end
  end

  // The edge register tracks pulse_on even while disabled, so a pulse that is
  // already high when enable rises does not look like a fresh rising edge.
  assign rise = pulse_on & ~pulse_prev_q;

  always_comb begin
    state_d      = state_q;
    blank_d      = blank_q;
    delay_d      = delay_q;
    pulse_prev_d = pulse_on;
    commit_valid = 1'b0;
    commit_class = CLS_NONE;
    commit_delay = delay_q;

    if (!enable) begin
      state_d = ST_IDLE;
      blank_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The edge cycle is blanking cycle 0; blank_q holds the index of
          // the cycle being evaluated in BLANK.
          if (rise) begin
            if (BLANK_CYCLES == 1) begin
              state_d = ST_WAIT_BD;
              delay_d = '0;
            end else begin
              state_d = ST_BLANK;
              blank_d = BW'(1);
            end
          end
        end
        ST_BLANK: begin
          if (!pulse_on) begin
            state_d = ST_IDLE;         // runt: nothing is counted
          end else if (blank_q == BLANK_LAST) begin
            state_d = ST_WAIT_BD;
            delay_d = '0;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
        ST_WAIT_BD: begin
          // delay_q stays 0 only on the first compare cycle (it saturates,
          // never wraps), so it doubles as the short-window flag.
          if (!pulse_on) begin
            commit_valid = 1'b1;
            commit_class = CLS_OPEN;
            state_d      = ST_IDLE;
          end else if ((delay_q == 16'd0) && (sample_voltage < V_SHORT_TH)) begin
            commit_valid = 1'b1;
            commit_class = CLS_SHORT;
            state_d      = ST_HOLD;
          end else if (sample_voltage < V_OPEN_TH) begin
            commit_valid = 1'b1;
            commit_class = CLS_NORMAL;
            state_d      = ST_HOLD;
          end else if (delay_q != 16'hFFFF) begin
            delay_d = delay_q + 16'd1;
          end
        end
        ST_HOLD: begin
          if (!pulse_on) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/gap_feedback_monitor.sv
// gap_feedback_monitor: per-window discharge statistics.
// Counts NORMAL/SHORT/OPEN pulses from gap_pulse_classifier over windows of
// WINDOW_CYCLES enabled cycles and publishes a packed 32-bit word with a
// one-cycle strobe on the cycle after each window's terminal cycle.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       slave side of gap_feedback_monitor_if:
//             enable, pulse_on, sample_voltage, sample_current in;
//             feedback_data {normal, short, open, delay field}, feedback_valid,
//             dbg_state, dbg_current out
module gap_feedback_monitor
  import gap_feedback_monitor_pkg::*;
#(
  parameter int          WINDOW_CYCLES = 1000000,
  parameter int          BLANK_CYCLES  = 8,
  parameter logic [15:0] V_OPEN_TH     = 16'd2000,
  parameter logic [15:0] V_SHORT_TH    = 16'd300,
  parameter int          DELAY_SHIFT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gap_feedback_monitor_if.slave  bus
);

  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

  logic        commit_valid;
  gap_class_e  commit_class;
  logic [15:0] commit_delay;
  gap_state_e  cls_state;

  gap_pulse_classifier #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .V_OPEN_TH    (V_OPEN_TH),
    .V_SHORT_TH   (V_SHORT_TH)
  ) u_classifier (
    .clk            (clk),
    .rst            (rst),
    .enable         (bus.enable),
    .pulse_on       (bus.pulse_on),
    .sample_voltage (bus.sample_voltage),
    .commit_valid   (commit_valid),
    .commit_class   (commit_class),
    .commit_delay   (commit_delay),
    .state_o        (cls_state)
  );

  logic [WW-1:0] win_q, win_d;
  logic [7:0]    normal_q, normal_d, short_q, short_d, open_q, open_d;
  logic [7:0]    last_delay_q, last_delay_d;
  logic [31:0]   fb_data_q, fb_data_d;
  logic          fb_valid_q, fb_valid_d;
  logic [15:0]   current_q, current_d;

  // Counts/field values including this cycle's commit, if any.
  logic [7:0]  normal_n, short_n, open_n, last_delay_n;
  logic [15:0] delay_shifted;
  logic [31:0] fb_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '0;
      normal_q     <= '0;
      short_q      <= '0;
      open_q       <= '0;
      last_delay_q <= '0;
      fb_data_q    <= '0;
      fb_valid_q   <= 1'b0;
      current_q    <= '0;
    end else begin
      win_q        <= win_d;
      normal_q     <= normal_d;
      short_q      <= short_d;
      open_q       <= open_d;
      last_delay_q <= last_delay_d;
      fb_data_q    <= fb_data_d;
      fb_valid_q   <= fb_valid_d;
      current_q    <= current_d;
    end
  end

  always_comb begin
    normal_n      = normal_q;
    short_n       = short_q;
    open_n        = open_q;
    last_delay_n  = last_delay_q;
    delay_shifted = commit_delay >> DELAY_SHIFT;
    if (commit_valid) begin
      unique case (commit_class)
        CLS_NORMAL: begin
          normal_n     = sat_inc8(normal_q);
          last_delay_n = (delay_shifted > 16'd255) ? 8'hFF : delay_shifted[7:0];
        end
        CLS_SHORT: short_n = sat_inc8(short_q);
        CLS_OPEN:  open_n  = sat_inc8(open_q);
        default:   ;
      endcase
    end

    fb_word = '0;
    fb_word[FB_NORMAL_LSB +: FB_FIELD_W] = normal_n;
    fb_word[FB_SHORT_LSB  +: FB_FIELD_W] = short_n;
    fb_word[FB_OPEN_LSB   +: FB_FIELD_W] = open_n;
    fb_word[FB_DELAY_LSB  +: FB_FIELD_W] = last_delay_n;

    win_d        = win_q;
    normal_d     = normal_q;
    short_d      = short_q;
    open_d       = open_q;
    last_delay_d = last_delay_n;
    fb_data_d    = fb_data_q;
    fb_valid_d   = 1'b0;
    current_d    = bus.sample_current;

    if (!bus.enable) begin
      win_d    = '0;
      normal_d = '0;
      short_d  = '0;
      open_d   = '0;
    end else if (win_q == WIN_LAST) begin
      // Terminal cycle: a same-cycle commit goes into this word only, so
      // the next window's counts restart from zero.
      win_d      = '0;
      fb_data_d  = fb_word;
      fb_valid_d = 1'b1;
      normal_d   = '0;
      short_d    = '0;
      open_d     = '0;
    end else begin
      win_d    = win_q + WW'(1);
      normal_d = normal_n;
      short_d  = short_n;
      open_d   = open_n;
    end
  end

  assign bus.feedback_data  = fb_data_q;
  assign bus.feedback_valid = fb_valid_q;
  assign bus.dbg_state      = cls_state;
  assign bus.dbg_current    = current_q;

endmodule

// File: tb/tb_gap_feedback_monitor.sv
module tb_gap_feedback_monitor;
  import gap_feedback_monitor_pkg::*;

  localparam int WIN     = 1000;
  localparam int SAT_WIN = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gap_feedback_monitor_if mif();
  gap_feedback_monitor_if sif();

  gap_feedback_monitor #(
    .WINDOW_CYCLES(WIN), .BLANK_CYCLES(8), .V_OPEN_TH(16'd2000),
    .V_SHORT_TH(16'd300), .DELAY_SHIFT(2)
  ) dut (.clk(clk), .rst(rst), .bus(mif));

  // Larger window instance used only for count/delay saturation.
  gap_feedback_monitor #(
    .WINDOW_CYCLES(SAT_WIN), .BLANK_CYCLES(8), .V_OPEN_TH(16'd2000),
    .V_SHORT_TH(16'd300), .DELAY_SHIFT(2)
  ) dut_sat (.clk(clk), .rst(rst), .bus(sif));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // index of the next window edge
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] sat_exp_q[$];
  logic [31:0] sat_got_q[$];
  logic [31:0] obs, expv;

  // Output capture: every strobe cycle records the published word.
  always @(negedge clk) begin
    if (mif.feedback_valid === 1'b1) got_q.push_back(mif.feedback_data);
    if (sif.feedback_valid === 1'b1) sat_got_q.push_back(sif.feedback_data);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    mif.sample_current = 16'($urandom_range(0, 65535));
    sif.sample_current = 16'($urandom_range(0, 65535));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic start_window();
    mif.enable = 1'b0;
    tick();
    mif.enable = 1'b1;
    cyc = 0;
  endtask

  // Pulse of len cycles; voltage v_hi before pulse cycle drop_at, v_lo from it on.
  task automatic drive_pulse(input int len, input int drop_at,
                             input logic [15:0] v_hi, input logic [15:0] v_lo);
    for (int c = 0; c < len; c++) begin
      mif.pulse_on       = 1'b1;
      mif.sample_voltage = (c >= drop_at) ? v_lo : v_hi;
      tick();
    end
    mif.pulse_on       = 1'b0;
    mif.sample_voltage = 16'd3000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (mif.feedback_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got 0x%08h expected 0x00000000", mif.feedback_data);
    end
    checks++;
    if (mif.feedback_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", mif.feedback_valid);
    end
    checks++;
    if (mif.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", mif.dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_short();
    start_window();
    wait_until(10);
    drive_pulse(50, 0, 16'd100, 16'd100);
    exp_q.push_back(32'h0001_0000);
    wait_until(WIN - 1);
    @(negedge clk); #1;
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL short_early_strobe: got %0d strobes expected 0", got_q.size());
    end
    wait_until(WIN + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL short_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL short_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_open_runt();
    start_window();
    wait_until(10);
    drive_pulse(50, 50, 16'd3000, 16'd3000);
    exp_q.push_back(32'h0000_0100);
    wait_until(WIN + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL open_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL open_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();
    // Runt: low voltage but pulse_on falls at cycle 5, inside blanking.
    wait_until(WIN + 20);
    drive_pulse(5, 0, 16'd100, 16'd100);
    exp_q.push_back(32'h0000_0000);
    wait_until(2 * WIN + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL runt_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL runt_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_normal();
    start_window();
    wait_until(10);
    drive_pulse(100, 20, 16'd3000, 16'd1000);   // delay 12 -> field 3
    exp_q.push_back(32'h0100_0003);
    wait_until(WIN - 1);
    @(negedge clk); #1;
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL normal_early_strobe: got %0d strobes expected 0", got_q.size());
    end
    wait_until(WIN + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL normal_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL normal_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_boundary();
    start_window();
    wait_until(WIN - 21);                        // edge at 979, commit at 999
    exp_q.push_back(32'h0100_0003);
    exp_q.push_back(32'h0000_0003);
    drive_pulse(100, 20, 16'd3000, 16'd1000);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL boundary_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL boundary_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    wait_until(2 * WIN + 2);
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL boundary_next_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL boundary_next_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_run();
    start_window();
    for (int k = 0; k < 3; k++) begin
      wait_until(10 + 100 * k);
      drive_pulse(50, 0, 16'd100, 16'd100);
    end
    wait_until(500);
    mif.enable = 1'b0;
    repeat (600) tick();
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL disable_strobe: got %0d strobes expected 0", got_q.size());
    end
    checks++;
    if (mif.feedback_data !== 32'h0000_0003) begin
      errors++; $display("FAIL disable_hold: got 0x%08h expected 0x00000003", mif.feedback_data);
    end
    // Pulse already high at enable rise: ignored; the 3 shorts were discarded.
    mif.pulse_on = 1'b1;
    mif.sample_voltage = 16'd100;
    start_window();
    exp_q.push_back(32'h0000_0003);
    repeat (30) tick();
    mif.pulse_on = 1'b0;
    mif.sample_voltage = 16'd3000;
    wait_until(WIN + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL reenable_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL reenable_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();

    // Reset in the middle of a pulse that is waiting for breakdown.
    start_window();
    wait_until(5);
    mif.pulse_on = 1'b1;
    mif.sample_voltage = 16'd3000;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mif.pulse_on = 1'b0;
    cyc = 0;
    checks++;
    if (mif.feedback_data !== 32'h0 || mif.feedback_valid !== 1'b0) begin
      errors++; $display("FAIL midpulse_rst_out: got 0x%08h/%b expected 0x00000000/0",
                         mif.feedback_data, mif.feedback_valid);
    end
    checks++;
    if (mif.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL midpulse_rst_state: got %0d expected %0d", mif.dbg_state, ST_IDLE);
    end
    exp_q.push_back(32'h0000_0000);
    wait_until(3);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL midpulse_rst_strobe: got %0d strobes expected 0", got_q.size());
    end
    wait_until(WIN + 2);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL post_rst_word: got %0d strobes expected 1", got_q.size());
    end else begin
      obs = got_q.pop_front(); expv = exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL post_rst_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    mif.enable = 1'b0;
    tick();
    sif.enable = 1'b1;
    cyc = 0;
    sat_exp_q.push_back(32'hFF00_00FF);
    for (int p = 0; p < 300; p++) begin
      for (int c = 0; c < 10; c++) begin
        sif.pulse_on = 1'b1;
        sif.sample_voltage = 16'd1000;
        tick();
      end
      sif.pulse_on = 1'b0;
      sif.sample_voltage = 16'd3000;
      tick();
    end
    // Last normal pulse has delay 2000 -> 500 after shift -> clamped to 255.
    for (int c = 0; c < 2020; c++) begin
      sif.pulse_on = 1'b1;
      sif.sample_voltage = (c < 2008) ? 16'd3000 : 16'd1000;
      tick();
    end
    sif.pulse_on = 1'b0;
    sif.sample_voltage = 16'd3000;
    wait_until(SAT_WIN + 2);
    checks++;
    if (sat_got_q.size() != 1) begin
      errors++; $display("FAIL sat_word: got %0d strobes expected 1", sat_got_q.size());
    end else begin
      obs = sat_got_q.pop_front(); expv = sat_exp_q.pop_front();
      if (obs !== expv) begin
        errors++; $display("FAIL sat_word: got 0x%08h expected 0x%08h", obs, expv);
      end
    end
    sat_got_q.delete(); sat_exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    mif.enable = 1'b0; mif.pulse_on = 1'b0;
    mif.sample_voltage = 16'd3000; mif.sample_current = 16'd0;
    sif.enable = 1'b0; sif.pulse_on = 1'b0;
    sif.sample_voltage = 16'd3000; sif.sample_current = 16'd0;
    test_reset();
    test_short();
    test_open_runt();
    test_normal();
    test_boundary();
    test_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
